// File: rtl/roll_button_ctrl_if.sv
// Button-to-dice-roller control bundle.
// The master side drives the raw button. The slave side returns debounced and roll status.
interface roll_button_ctrl_if;
    logic       btn_in;
    logic       btn_db;
    logic       roll;
    logic       rolling;
    logic       result_valid;
    logic [7:0] roll_count;

    modport master (
        output btn_in,
        input  btn_db,
        input  roll,
        input  rolling,
        input  result_valid,
        input  roll_count
    );

    modport slave (
        input  btn_in,
        output btn_db,
        output roll,
        output rolling,
        output result_valid,
        output roll_count
    );
endinterface

// File: rtl/roll_button_ctrl.sv
// Dice roller front end: synchronise, debounce and edge-detect the button.
// Hold roll for the press with a minimum spin, then pulse result_valid.
module roll_button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 2500000,
    parameter int MIN_SPIN_CYCLES = 64
) (
    input logic               clk,
    input logic               rst,
    roll_button_ctrl_if.slave bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int SP_W = $clog2(MIN_SPIN_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SP_W-1:0] SP_SAT  = SP_W'(MIN_SPIN_CYCLES);
    localparam logic [SP_W-1:0] SP_EXIT = SP_W'(MIN_SPIN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SPIN,
        SETTLE,
        DONE
    } state_t;

    logic            sync1_q;
    logic            btn_s_q;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            btn_db_q;
    logic            btn_db_d;
    logic            btn_dly_q;
    logic            press;

    state_t          state_q;
    logic [SP_W-1:0] spin_cnt_q;
    logic            roll_q;
    logic            rolling_q;
    logic            result_valid_q;
    logic [7:0]      roll_count_q;

    always_comb begin
        db_cnt_d = '0;
        btn_db_d = btn_db_q;
        if (btn_s_q != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_d = btn_s_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            btn_s_q   <= 1'b0;
            db_cnt_q  <= '0;
            btn_db_q  <= 1'b0;
            btn_dly_q <= 1'b0;
        end else begin
            sync1_q   <= bus.btn_in;
            btn_s_q   <= sync1_q;
            db_cnt_q  <= db_cnt_d;
            btn_db_q  <= btn_db_d;
            btn_dly_q <= btn_db_q;
        end
    end

    // Presses seen outside IDLE are swallowed here; a re-press is needed.
    assign press = btn_db_q & ~btn_dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            spin_cnt_q     <= '0;
            roll_q         <= 1'b0;
            rolling_q      <= 1'b0;
            result_valid_q <= 1'b0;
            roll_count_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (press) begin
                        state_q    <= SPIN;
                        spin_cnt_q <= '0;
                        roll_q     <= 1'b1;
                        rolling_q  <= 1'b1;
                    end
                end
                SPIN: begin
                    if (spin_cnt_q != SP_SAT) begin
                        spin_cnt_q <= spin_cnt_q + 1'b1;
                    end
                    if (!btn_db_q && spin_cnt_q >= SP_EXIT) begin
                        state_q <= SETTLE;
                        roll_q  <= 1'b0;
                    end
                end
                SETTLE: begin
                    state_q        <= DONE;
                    result_valid_q <= 1'b1;
                end
                DONE: begin
                    state_q        <= IDLE;
                    result_valid_q <= 1'b0;
                    rolling_q      <= 1'b0;
                    roll_count_q   <= roll_count_q + 8'd1;
                end
            endcase
        end
    end

    assign bus.btn_db       = btn_db_q;
    assign bus.roll         = roll_q;
    assign bus.rolling      = rolling_q;
    assign bus.result_valid = result_valid_q;
    assign bus.roll_count   = roll_count_q;
endmodule

// File: tb/tb_roll_button_ctrl.sv
// Bench for roll_button_ctrl: two instances (min spin 4 and 40) share one button.
// Both are checked every cycle against an event-level model of the button and roll timeline.
module tb_roll_button_ctrl;
    localparam int DEB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    roll_button_ctrl_if if0 ();
    roll_button_ctrl_if if1 ();

    assign if0.btn_in = btn;
    assign if1.btn_in = btn;

    roll_button_ctrl #(.DEBOUNCE_CYCLES(DEB), .MIN_SPIN_CYCLES(4)) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(if0)
    );

    roll_button_ctrl #(.DEBOUNCE_CYCLES(DEB), .MIN_SPIN_CYCLES(40)) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(if1)
    );

    always #5 clk = ~clk;

    // Model: btn_s is btn two edges late; btn_db flips after DEB consecutive disagreeing edges.
    // Roll lasts max(MIN, press-hold) cycles, then a one-cycle gap, then the result pulse.
    int m_s1[2], m_s2[2], m_db[2], m_dbd[2], m_run[2];
    int m_spun[2], m_after[2], m_cnt[2];
    int dbr[2], rr[2], len[2], rv_m[2], rvc[2];

    function automatic int min_of(int i);
        return (i == 0) ? 4 : 40;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_dbd[i] = 0;
            m_run[i] = 0; m_spun[i] = 0; m_after[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic step(input int b);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            int old_db;
            int press;
            old_db = m_db[i];
            press  = (m_db[i] == 1 && m_dbd[i] == 0) ? 1 : 0;
            if (m_after[i] == 2) begin
                m_after[i] = 0;
                m_spun[i]  = 0;
                m_cnt[i]++;
            end else if (m_after[i] == 1) begin
                m_after[i] = 2;
                rv_m[i]++;
                rvc[i] = cyc;
            end else if (m_spun[i] > 0) begin
                if (m_db[i] == 1 || m_spun[i] < min_of(i)) begin
                    m_spun[i]++;
                end else begin
                    m_after[i] = 1;
                    len[i] = m_spun[i];
                end
            end else if (press == 1) begin
                m_spun[i] = 1;
                rr[i] = cyc;
            end
            if (m_s2[i] != m_db[i]) begin
                if (m_run[i] + 1 == DEB) begin
                    m_db[i]  = m_s2[i];
                    m_run[i] = 0;
                    if (m_db[i] == 1) dbr[i] = cyc;
                end else begin
                    m_run[i]++;
                end
            end else begin
                m_run[i] = 0;
            end
            m_dbd[i] = old_db;
            m_s2[i]  = m_s1[i];
            m_s1[i]  = b;
        end
    endtask

    task automatic chk(input string nm, input int i, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[%0d] cyc=%0d got %0d want %0d", nm, i, cyc, act, exp);
        end
    endtask

    function automatic logic [11:0] outs(int i);
        if (i == 0)
            return {if0.btn_db, if0.roll, if0.rolling, if0.result_valid, if0.roll_count};
        return {if1.btn_db, if1.roll, if1.rolling, if1.result_valid, if1.roll_count};
    endfunction

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            logic [11:0] o;
            o = outs(i);
            chk("btn_db", i, int'(o[11]), m_db[i]);
            chk("roll", i, int'(o[10]), (m_spun[i] > 0 && m_after[i] == 0) ? 1 : 0);
            chk("rolling", i, int'(o[9]), (m_spun[i] > 0) ? 1 : 0);
            chk("result_valid", i, int'(o[8]), (m_after[i] == 2) ? 1 : 0);
            chk("roll_count", i, int'(o[7:0]), m_cnt[i] % 256);
        end
    endtask

    task automatic cycle(input int b);
        @(negedge clk);
        compare_all();
        btn = b[0];
        step(b);
    endtask

    task automatic run(input int n, input int b);
        for (int k = 0; k < n; k++) cycle(b);
    endtask

    // Reset lands between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        btn = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) chk("rst_outs", i, int'(outs(i)), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(0);
    endtask

    initial begin
        int start;
        int rv0;
        int rv1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            dbr[i] = 0; rr[i] = 0; len[i] = 0; rv_m[i] = 0; rvc[i] = 0;
        end
        repeat (3) @(negedge clk);
        do_reset();

        // glitch shorter than the debounce window
        run(5, 1);
        run(30, 0);
        chk("glitch_rv", 0, rv_m[0] + rv_m[1], 0);
        chk("glitch_cnt", 0, m_cnt[0], 0);

        // clean 30-cycle press
        start = cyc;
        run(30, 1);
        run(80, 0);
        chk("db_lat", 0, dbr[0] - start, 10);
        chk("roll_lat", 0, rr[0] - start, 11);
        chk("roll_len", 0, len[0], 30);
        chk("roll_len", 1, len[1], 40);
        chk("rv_gap", 0, rvc[0] - (rr[0] + len[0] - 1), 2);
        chk("clean_rv", 0, rv_m[0], 1);
        chk("clean_cnt", 0, m_cnt[0], 1);

        // short press: minimum spin governs the slow instance
        run(12, 1);
        run(80, 0);
        chk("min_len", 0, len[0], 12);
        chk("min_len", 1, len[1], 40);
        chk("min_cnt", 1, m_cnt[1], 2);

        // reset three cycles into the spin
        run(13, 1);
        do_reset();
        run(20, 0);
        chk("rst_cnt", 0, m_cnt[0], 0);

        // bounce then stable press, twice
        rv0 = rv_m[0];
        rv1 = rv_m[1];
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 20; j++) cycle(((j / 3) % 2 == 0) ? 1 : 0);
            run(30, 1);
            run(80, 0);
        end
        chk("bounce_rv", 0, rv_m[0] - rv0, 2);
        chk("bounce_rv", 1, rv_m[1] - rv1, 2);
        chk("bounce_cnt", 0, m_cnt[0], 2);

        // random bursts
        for (int k = 0; k < 60; k++) begin
            run(int'($urandom_range(1, 50)), int'($urandom_range(0, 1)));
        end
        run(100, 0);

        // 256 rolls wrap the counter
        do_reset();
        for (int k = 0; k < 256; k++) begin
            run(12, 1);
            run(60, 0);
        end
        chk("wrap_total", 0, m_cnt[0], 256);
        chk("wrap_total", 1, m_cnt[1], 256);
        run(2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
